frame_buffer_ctrl: RTL and testbench

Double-buffer controller sequencing the 320x240 1-bit `interlaced_buffer` frame store.
- Write side: accepts a camera pixel stream and generates write enable, address and bank.
- Read side: generates the display read address and bank.
- Bank swaps happen only at display frame boundaries, so the display never shows a torn frame.
- Sits between the camera capture logic and the two buffer banks feeding the VGA/display path.

---
 rtl/frame_buffer_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// frame_buffer_ctrl
//   Double-buffer controller for a 1-bit 320x240 interlaced frame store.
//   The writer fills one bank from the camera pixel stream while the reader
//   scans the other bank for the display. Banks are exchanged only when the
//   reader wraps at the end of a display frame (or straight away if the reader
//   has never run), so the display never shows a torn frame.
//
//   Optional feature macro: FRAME_DROP_CNT_EN
//     When defined, adds drop_cnt[15:0], a saturating count of camera frames
//     whose frame_start arrived while a finished frame was still waiting to be
//     shown (writer in W_HOLD, excluding the swap cycle).
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   px_in        in   camera pixel data
//   px_valid     in   px_in valid this cycle
//   frame_start  in   pulse marking the first pixel of a camera frame
//   rd_advance   in   display consumed the pixel at rd_addr
//   wr_en        out  write strobe to the buffer (1 cycle after px_valid)
//   wr_addr      out  write address
//   wr_bank      out  bank being written
//   px_out       out  registered px_in, aligned with wr_en
//   rd_addr      out  read address
//   rd_bank      out  bank being displayed (always ~wr_bank)
//   rd_valid     out  display bank holds a complete frame
//   frame_done   out  pulse with the last write of a frame
//   swap         out  pulse: banks exchanged
//   drop_cnt     out  (FRAME_DROP_CNT_EN only) dropped-frame counter
// -----------------------------------------------------------------------------
module frame_buffer_ctrl #(
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 17,
  parameter int PIXEL_W      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] px_in,
  input  logic               px_valid,
  input  logic               frame_start,
  input  logic               rd_advance,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               wr_bank,
  output logic [PIXEL_W-1:0] px_out,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_bank,
  output logic               rd_valid,
  output logic               frame_done,
  output logic               swap
`ifdef FRAME_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  typedef enum logic [1:0] {
    W_WAIT_SOF = 2'd0,
    W_FILL     = 2'd1,
    W_HOLD     = 2'd2
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rstate_e;

  wstate_e              wstate_q;
  rstate_e              rstate_q;
  logic [ADDR_W-1:0]    wcnt_q;       // next write address
  logic                 ready_q;      // a complete frame waits in the write bank
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [PIXEL_W-1:0]   px_out_q;
  logic                 wr_bank_q;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic                 rd_valid_q;
  logic                 frame_done_q;
  logic                 swap_q;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0]          drop_cnt_q;
`endif

  logic rd_wrap_s;
  logic swap_s;

  // Reader hits the end of the display frame this cycle.
  assign rd_wrap_s = (rstate_q == R_RUN) && rd_advance && (rd_addr_q == LAST_ADDR);
  // Exchange banks on a ready frame either at start-up (reader idle) or on a wrap.
  // ready_q is registered, so a frame finishing in the wrap cycle waits one frame.
  assign swap_s = ready_q && ((rstate_q == R_IDLE) || rd_wrap_s);

  // Writer and reader state machines with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q     <= W_WAIT_SOF;
      rstate_q     <= R_IDLE;
      wcnt_q       <= '0;
      ready_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      px_out_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      swap_q       <= 1'b0;
`ifdef FRAME_DROP_CNT_EN
      drop_cnt_q   <= 16'h0000;
`endif
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      swap_q       <= 1'b0;

      case (wstate_q)
        W_WAIT_SOF, W_FILL: begin
          if (frame_start) begin
            // Start (or restart) a frame at address 0; partial frames are dropped.
            wstate_q <= W_FILL;
            if (px_valid) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              px_out_q  <= px_in;
              wcnt_q    <= ONE_ADDR;
            end else begin
              wcnt_q    <= '0;
            end
          end else if ((wstate_q == W_FILL) && px_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wcnt_q;
            px_out_q  <= px_in;
            if (wcnt_q == LAST_ADDR) begin
              ready_q      <= 1'b1;
              frame_done_q <= 1'b1;
              wstate_q     <= W_HOLD;
            end else begin
              wcnt_q <= wcnt_q + ONE_ADDR;
            end
          end
        end
        W_HOLD: begin
          if (swap_s) begin
            wstate_q <= W_WAIT_SOF;
          end
        end
        default: wstate_q <= W_WAIT_SOF;
      endcase

      case (rstate_q)
        R_IDLE: begin
          if (ready_q) begin
            rstate_q   <= R_RUN;
            rd_valid_q <= 1'b1;
            rd_addr_q  <= '0;
          end
        end
        R_RUN: begin
          if (rd_advance) begin
            rd_addr_q <= (rd_addr_q == LAST_ADDR) ? '0 : (rd_addr_q + ONE_ADDR);
          end
        end
        default: rstate_q <= R_IDLE;
      endcase

      // Placed last so the ready clear wins over any other update.
      if (swap_s) begin
        wr_bank_q <= ~wr_bank_q;
        ready_q   <= 1'b0;
        swap_q    <= 1'b1;
      end

`ifdef FRAME_DROP_CNT_EN
      if ((wstate_q == W_HOLD) && frame_start && !swap_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'h0001;
      end
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_bank    = wr_bank_q;
  assign rd_bank    = ~wr_bank_q;  // derived so the banks can never coincide
  assign px_out     = px_out_q;
  assign rd_addr    = rd_addr_q;
  assign rd_valid   = rd_valid_q;
  assign frame_done = frame_done_q;
  assign swap       = swap_q;
`ifdef FRAME_DROP_CNT_EN
  assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl using a reduced frame size (1000 pixels,
// 10-bit addresses) so full-frame scenarios stay short. Expected writes are
// queued as stimulus is driven and popped when wr_en appears.
module tb_frame_buffer_ctrl;

  localparam int N  = 1000;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [0:0]    px_in = 1'b0;
  logic          px_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          rd_advance = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic [0:0]    px_out;
  logic [AW-1:0] rd_addr;
  logic          rd_bank;
  logic          rd_valid;
  logic          frame_done;
  logic          swap;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [AW:0] exp_q[$];   // {px, addr}

  always #5 clk = ~clk;

  frame_buffer_ctrl #(
    .FRAME_PIXELS(N),
    .ADDR_W      (AW),
    .PIXEL_W     (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .px_in      (px_in),
    .px_valid   (px_valid),
    .frame_start(frame_start),
    .rd_advance (rd_advance),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_bank    (wr_bank),
    .px_out     (px_out),
    .rd_addr    (rd_addr),
    .rd_bank    (rd_bank),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .swap       (swap)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected write, check after the edge.
  task automatic step(input logic fs, input logic pv, input logic px, input logic adv,
                      input logic ew, input int ea, input logic efd, input logic esw);
    logic [AW:0] e;
    frame_start = fs;
    px_valid    = pv;
    px_in       = px;
    rd_advance  = adv;
    if (ew) exp_q.push_back({px, ea[AW-1:0]});
    @(posedge clk);
    #1;
    chk("wr_en", 32'(wr_en), 32'(ew));
    if (ew && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_addr", 32'(wr_addr), 32'(e[AW-1:0]));
      chk("px_out", 32'(px_out), 32'(e[AW]));
    end
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("swap", 32'(swap), 32'(esw));
    chk("bank_differ", 32'(wr_bank ^ rd_bank), 32'd1);
  endtask

  initial begin
    logic p;

    // Reset held 10 cycles.
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_wr_bank", 32'(wr_bank), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_swap", 32'(swap), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    // First frame: half zeros, half ones, continuous px_valid.
    for (int i = 0; i < N; i++) step(i == 0, 1'b1, (i >= N/2), 1'b0, 1'b1, i, (i == N-1), 1'b0);
    // Reader idle picks up the ready frame one cycle later.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    chk("p1_rd_bank", 32'(rd_bank), 32'd0);
    chk("p1_wr_bank", 32'(wr_bank), 32'd1);
    chk("p1_rd_valid", 32'(rd_valid), 32'd1);
    chk("p1_rd_addr", 32'(rd_addr), 32'd0);

    // Full read pass with no new frame: wrap without swap.
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk("p2_rd_addr", 32'(rd_addr), 32'((i + 1) % N));
    end
    chk("p2_rd_bank", 32'(rd_bank), 32'd0);
    chk("p2_rd_valid", 32'(rd_valid), 32'd1);

    // Second frame completes while the reader is at 300.
    for (int i = 0; i < N; i++) begin
      p = 1'($urandom_range(0, 1));
      step(i == 0, 1'b1, p, (i >= N-300), 1'b1, i, (i == N-1), 1'b0);
    end
    chk("p3_rd_addr", 32'(rd_addr), 32'd300);
    // Writer holds: pixels and frame_start ignored.
    for (int h = 0; h < 5; h++) step(h < 3, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
`ifdef FRAME_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd3);
`endif
    // Swap exactly on the advance at the last address.
    for (int j = 0; j < N-305; j++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, (j == N-306));
    chk("p3_rd_addr_wrap", 32'(rd_addr), 32'd0);
    chk("p3_wr_bank", 32'(wr_bank), 32'd0);
    chk("p3_rd_bank", 32'(rd_bank), 32'd1);

    // Pixels before frame_start are ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // Partial frame of 50, then frame_start with a pixel restarts at 0.
    for (int i = 0; i < 50; i++) step(i == 0, 1'b1, i[0], 1'b0, 1'b1, i, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(i == 0, 1'b1, ~i[0], 1'b0, 1'b1, i, 1'b0, 1'b0);
    // frame_start alone restarts with the next pixel at 0.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      p = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, p, 1'b0, 1'b1, i, (i == N-1), 1'b0);
    end
    // Reader is running and not wrapping: no swap yet.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("p4_rd_bank", 32'(rd_bank), 32'd1);

    // Mid-activity reset returns everything to reset values.
    reset = 1'b1;
    frame_start = 1'b1;
    px_valid = 1'b1;
    rd_advance = 1'b1;
    @(posedge clk);
    #1;
    chk("r2_wr_bank", 32'(wr_bank), 32'd0);
    chk("r2_rd_bank", 32'(rd_bank), 32'd1);
    chk("r2_rd_valid", 32'(rd_valid), 32'd0);
    chk("r2_wr_en", 32'(wr_en), 32'd0);
    chk("r2_wr_addr", 32'(wr_addr), 32'd0);
    chk("r2_rd_addr", 32'(rd_addr), 32'd0);
    chk("r2_px_out", 32'(px_out), 32'd0);
`ifdef FRAME_DROP_CNT_EN
    chk("r2_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    reset = 1'b0;
    // Ready was cleared: reader stays idle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("r2_rd_valid_idle", 32'(rd_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
